// File: rtl/sc_spi_tgt.sv
// SPI target engine: oversamples CSB/SCLK/MOSI on SPICLK, shifts MISO from the TX word buffer
// and assembles received words for the RX buffer.
module sc_spi_tgt #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        SPICLK,
  input  logic        SYSRSTB,
  input  logic        CPOL,
  input  logic        CPHA,
  input  logic        BORDER,
  input  logic [31:0] TXDATA,
  output logic [3:0]  TXDPT,
  output logic [31:0] RXDATA,
  output logic        RXVALID,
  output logic [3:0]  RXDPT,
  output logic        FRMACT,
  output logic        FRMDONE,
  output logic [9:0]  FRMBITS,
  output logic        OVERRUN,
  input  logic        CSB,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISOOE
);

  // state  | meaning
  // IDLE   | waiting for an armed CSB falling edge
  // ACTIVE | frame in progress, SCLK edges sample/shift
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] csb_sync, sclk_sync, mosi_sync, vld_sync;
  logic        csb_s, sclk_s, mosi_s, csb_q, sclk_q, armed;
  logic        csb_fall, csb_rise, sclk_rise, sclk_fall;
  logic        lead_edge, trail_edge, smp_edge, shf_edge;
  logic        start, stop, do_samp, do_shift;
  logic [9:0]  bc;
  logic [31:0] acc, acc_set;
  logic [4:0]  rx_pos, tx_pos;

  // Wire bit b of a word -> word bit index; byte order from BORDER, MSB first within a byte.
  function automatic logic [4:0] wpos(input logic [4:0] b, input logic border);
    logic [1:0] k;
    k = border ? b[4:3] : ~b[4:3];
    return {k, ~b[2:0]};
  endfunction

  assign csb_s  = csb_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // vld_sync marks when the synchronizer outputs carry real pin values, so the reset value
  // of the CSB synchronizer can never arm the engine.
  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      csb_sync  <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      vld_sync  <= '0;
      csb_q     <= 1'b1;
      sclk_q    <= 1'b0;
      armed     <= 1'b0;
    end else begin
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], CSB};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
      csb_q     <= csb_s;
      sclk_q    <= sclk_s;
      if (vld_sync[SYNC_STAGES-1] && csb_s) armed <= 1'b1;
    end
  end

  assign csb_fall   = !csb_s && csb_q;
  assign csb_rise   = csb_s && !csb_q;
  assign sclk_rise  = sclk_s && !sclk_q;
  assign sclk_fall  = !sclk_s && sclk_q;
  assign lead_edge  = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge = CPOL ? sclk_rise : sclk_fall;
  assign smp_edge   = CPHA ? trail_edge : lead_edge;
  assign shf_edge   = CPHA ? lead_edge : trail_edge;

  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    stop      = 1'b0;
    case (state)
      IDLE: begin
        if (csb_fall && armed) begin
          state_nxt = ACTIVE;
          start     = 1'b1;
        end
      end
      ACTIVE: begin
        if (csb_rise) begin
          state_nxt = IDLE;
          stop      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // CSB rising wins over a coincident SCLK edge.
  assign do_samp  = (state == ACTIVE) && !csb_rise && smp_edge;
  assign do_shift = (state == ACTIVE) && !csb_rise && shf_edge;

  assign rx_pos = wpos(bc[4:0], BORDER);
  assign tx_pos = wpos(bc[4:0], BORDER);

  always_comb begin
    acc_set         = acc;
    acc_set[rx_pos] = mosi_s;
  end

  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      bc      <= '0;
      acc     <= '0;
      RXDATA  <= '0;
      RXVALID <= 1'b0;
      RXDPT   <= '0;
      FRMDONE <= 1'b0;
      FRMBITS <= '0;
      OVERRUN <= 1'b0;
      MISO    <= 1'b0;
    end else begin
      RXVALID <= 1'b0;
      FRMDONE <= 1'b0;
      if (start) begin
        bc      <= '0;
        acc     <= '0;
        OVERRUN <= 1'b0;
        MISO    <= CPHA ? 1'b0 : TXDATA[wpos(5'd0, BORDER)];
      end else if (stop) begin
        FRMDONE <= 1'b1;
        FRMBITS <= bc;
        MISO    <= 1'b0;
        bc      <= '0;
        acc     <= '0;
        if (bc[4:0] != 5'd0 && !bc[9]) begin
          RXDATA  <= acc;
          RXDPT   <= bc[8:5];
          RXVALID <= 1'b1;
        end
      end else if (do_samp) begin
        if (bc[9]) begin
          OVERRUN <= 1'b1;
        end else begin
          bc <= bc + 10'd1;
          if (bc[4:0] == 5'd31) begin
            RXDATA  <= acc_set;
            RXDPT   <= bc[8:5];
            RXVALID <= 1'b1;
            acc     <= '0;
          end else begin
            acc <= acc_set;
          end
        end
      end else if (do_shift) begin
        MISO <= bc[9] ? 1'b0 : TXDATA[tx_pos];
      end
    end
  end

  assign TXDPT  = bc[8:5];
  assign FRMACT = (state == ACTIVE);
  assign MISOOE = FRMACT;

endmodule

// File: tb/tb_sc_spi_tgt.sv
// Directed bench for sc_spi_tgt: a behavioural SPI initiator drives frames, RX words and frame
// results are queued when driven and compared when the target reports them.
module tb_sc_spi_tgt;

  localparam int H = 60;

  logic        SPICLK, SYSRSTB, CPOL, CPHA, BORDER, CSB, SCLK, MOSI;
  logic [31:0] TXDATA, RXDATA;
  logic [3:0]  TXDPT, RXDPT;
  logic        RXVALID, FRMACT, FRMDONE, OVERRUN, MISO, MISOOE;
  logic [9:0]  FRMBITS;

  logic [31:0] txmem [16];
  logic [31:0] mosi_words [16];
  logic [35:0] rxq [$];
  logic [10:0] frq [$];
  int errors = 0;
  int checks = 0;

  assign TXDATA = txmem[TXDPT];

  sc_spi_tgt #(.SYNC_STAGES(2)) dut (
    .SPICLK(SPICLK), .SYSRSTB(SYSRSTB), .CPOL(CPOL), .CPHA(CPHA), .BORDER(BORDER),
    .TXDATA(TXDATA), .TXDPT(TXDPT), .RXDATA(RXDATA), .RXVALID(RXVALID), .RXDPT(RXDPT),
    .FRMACT(FRMACT), .FRMDONE(FRMDONE), .FRMBITS(FRMBITS), .OVERRUN(OVERRUN),
    .CSB(CSB), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .MISOOE(MISOOE)
  );

  initial SPICLK = 1'b0;
  always #5 SPICLK = ~SPICLK;

  function automatic int wpos(input int b, input bit border);
    int k, j;
    k = b / 8;
    j = b % 8;
    return border ? (8 * k + 7 - j) : (31 - 8 * k - j);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input int nbits, input bit cpol, input bit cpha, input bit border,
                      input bit do_end);
    int eb, rem;
    logic [31:0] e;
    bit bv, mexp;
    CPOL = cpol; CPHA = cpha; BORDER = border; SCLK = cpol; MOSI = 1'b0;
    #200;
    for (int w = 0; w < 16; w++)
      if ((w + 1) * 32 <= nbits) rxq.push_back({4'(w), mosi_words[w]});
    if (do_end) begin
      eb  = (nbits > 512) ? 512 : nbits;
      rem = eb % 32;
      if (rem != 0) begin
        e = '0;
        for (int j = 0; j < rem; j++) e[wpos(j, border)] = mosi_words[eb/32][wpos(j, border)];
        rxq.push_back({4'(eb / 32), e});
      end
      frq.push_back({rem != 0, 10'(eb)});
    end
    CSB = 1'b0;
    #(2 * H);
    for (int i = 0; i < nbits; i++) begin
      bv   = (i < 512) ? mosi_words[i/32][wpos(i % 32, border)] : 1'b1;
      mexp = (i < 512) ? txmem[i/32][wpos(i % 32, border)] : 1'b0;
      if (!cpha) begin
        MOSI = bv;
        #H;
        check($sformatf("miso_bit%0d", i), {31'b0, MISO}, {31'b0, mexp});
        SCLK = ~cpol;
        #H;
        SCLK = cpol;
      end else begin
        SCLK = ~cpol;
        MOSI = bv;
        #H;
        check($sformatf("miso_bit%0d", i), {31'b0, MISO}, {31'b0, mexp});
        SCLK = cpol;
        #H;
      end
    end
    if (!cpha) #H;
    if (do_end) begin
      CSB = 1'b1;
      #(4 * H);
    end
  endtask

  always @(negedge SPICLK) begin : monitor
    logic [35:0] r;
    logic [10:0] f;
    if (RXVALID === 1'b1) begin
      check("rx_expected", {31'b0, RXVALID}, {31'b0, rxq.size() != 0});
      if (rxq.size() != 0) begin
        r = rxq.pop_front();
        check("rxdata", RXDATA, r[31:0]);
        check("rxdpt", {28'b0, RXDPT}, {28'b0, r[35:32]});
      end
    end
    if (FRMDONE === 1'b1) begin
      check("frm_expected", {31'b0, FRMDONE}, {31'b0, frq.size() != 0});
      if (frq.size() != 0) begin
        f = frq.pop_front();
        check("frmbits", {22'b0, FRMBITS}, {22'b0, f[9:0]});
        check("flush_with_done", {31'b0, RXVALID}, {31'b0, f[10]});
      end
    end
  end

  initial begin
    SYSRSTB = 1'b0; CSB = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    CPOL = 1'b0; CPHA = 1'b0; BORDER = 1'b0;
    for (int w = 0; w < 16; w++) begin
      txmem[w] = '0;
      mosi_words[w] = '0;
    end
    #40;
    check("rst_txdpt", {28'b0, TXDPT}, 32'd0);
    check("rst_rxdata", RXDATA, 32'd0);
    check("rst_rxvalid", {31'b0, RXVALID}, 32'd0);
    check("rst_rxdpt", {28'b0, RXDPT}, 32'd0);
    check("rst_frmact", {31'b0, FRMACT}, 32'd0);
    check("rst_frmdone", {31'b0, FRMDONE}, 32'd0);
    check("rst_frmbits", {22'b0, FRMBITS}, 32'd0);
    check("rst_overrun", {31'b0, OVERRUN}, 32'd0);
    check("rst_miso", {31'b0, MISO}, 32'd0);
    check("rst_misooe", {31'b0, MISOOE}, 32'd0);
    SYSRSTB = 1'b1;
    #100;

    // mode 0, BORDER=0, one word
    txmem[0] = 32'hA5C3_0F12;
    mosi_words[0] = 32'h1234_5678;
    xfer(32, 1'b0, 1'b0, 1'b0, 1'b1);

    // modes 1/2/3, BORDER=1, two words
    txmem[0] = 32'h0403_0201;
    txmem[1] = 32'h0807_0605;
    mosi_words[0] = 32'hDEAD_BEEF;
    mosi_words[1] = 32'hCAFE_F00D;
    xfer(64, 1'b0, 1'b1, 1'b1, 1'b1);
    xfer(64, 1'b1, 1'b0, 1'b1, 1'b1);
    xfer(64, 1'b1, 1'b1, 1'b1, 1'b1);

    // 12-bit partial word flushed at CSB rise
    mosi_words[0] = 32'hABC0_0000;
    xfer(12, 1'b0, 1'b0, 1'b0, 1'b1);

    // 520-bit overrun frame
    for (int w = 0; w < 16; w++) begin
      txmem[w] = $urandom;
      mosi_words[w] = $urandom;
    end
    xfer(520, 1'b0, 1'b0, 1'b0, 1'b1);
    check("overrun_set", {31'b0, OVERRUN}, 32'd1);
    frq.push_back({1'b0, 10'd0});
    CSB = 1'b0;
    #100;
    check("overrun_cleared", {31'b0, OVERRUN}, 32'd0);
    check("empty_frmact", {31'b0, FRMACT}, 32'd1);
    CSB = 1'b1;
    #100;

    // CSB held low across reset release must not start a frame
    SYSRSTB = 1'b0; CSB = 1'b0; SCLK = 1'b0; CPOL = 1'b0; CPHA = 1'b0;
    #40;
    SYSRSTB = 1'b1;
    for (int n = 0; n < 12; n++) begin
      #H;
      SCLK = ~SCLK;
    end
    #H;
    check("noarm_frmact", {31'b0, FRMACT}, 32'd0);
    check("noarm_misooe", {31'b0, MISOOE}, 32'd0);
    CSB = 1'b1;
    #100;
    frq.push_back({1'b0, 10'd0});
    CSB = 1'b0;
    #100;
    check("armed_frmact", {31'b0, FRMACT}, 32'd1);
    CSB = 1'b1;
    #100;
    check("armed_frmact_end", {31'b0, FRMACT}, 32'd0);

    // reset in the middle of a word, then a clean frame
    mosi_words[0] = 32'h1357_9BDF;
    txmem[0] = 32'hF0E1_D2C3;
    xfer(17, 1'b0, 1'b0, 1'b0, 1'b0);
    SYSRSTB = 1'b0;
    #20;
    check("midrst_frmact", {31'b0, FRMACT}, 32'd0);
    check("midrst_rxdata", RXDATA, 32'd0);
    check("midrst_rxvalid", {31'b0, RXVALID}, 32'd0);
    check("midrst_frmdone", {31'b0, FRMDONE}, 32'd0);
    check("midrst_frmbits", {22'b0, FRMBITS}, 32'd0);
    check("midrst_miso", {31'b0, MISO}, 32'd0);
    check("midrst_txdpt", {28'b0, TXDPT}, 32'd0);
    CSB = 1'b1;
    #30;
    SYSRSTB = 1'b1;
    #100;
    mosi_words[0] = 32'h5A5A_C33C;
    txmem[0] = 32'h0F0F_1234;
    xfer(32, 1'b0, 1'b0, 1'b0, 1'b1);

    #200;
    check("rxq_drained", 32'(rxq.size()), 32'd0);
    check("frq_drained", 32'(frq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
